// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and widths for the pipeline hazard controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_CNT_W = 32;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // True when an operand the ID instruction actually reads comes from rd.
  function automatic logic src_hit(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sat_cnt.sv
// ============================================================================
// hazard_sat_cnt : saturating up-counter with async reset and increment enable.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : load-use bubble, memory-wait freeze and branch flush control.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_ex_memRead,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mem_memAccess,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  redirect_en,
  output logic                  mem_timeout_err,
  output logic [PERF_CNT_W-1:0] perf_lu_cnt,
  output logic [PERF_CNT_W-1:0] perf_wait_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;

  logic mem_wait;
  logic load_use;
  logic flush_apply;
  logic lu_apply;

  assign mem_wait    = ex_mem_memAccess & ~dmem_ready;
  assign load_use    = id_ex_memRead && (id_ex_rd != '0) &&
                       (src_hit(id_rs1_used, id_rs1, id_ex_rd) ||
                        src_hit(id_rs2_used, id_rs2, id_ex_rd));
  assign flush_apply = ex_branch_taken & ~mem_wait;
  assign lu_apply    = load_use & ~mem_wait & ~ex_branch_taken;

  // Controls are gated by reset so nothing moves while reset is held.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    redirect_en  = 1'b0;
    if (!reset) begin
      if (mem_wait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (flush_apply) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        redirect_en  = 1'b1;
      end else if (lu_apply) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mem_wait)  state_d = WAIT;
      WAIT:    if (!mem_wait) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The stall is never force-released on timeout; only the sticky flag sets.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    err_d = err_q | (mem_wait && (wait_cnt_q == TIMEOUT_V));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
  hazard_sat_cnt #(.W(PERF_CNT_W)) u_perf_lu (
    .clk   (clk),
    .reset (reset),
    .inc   (lu_apply),
    .cnt   (perf_lu_cnt)
  );

  hazard_sat_cnt #(.W(PERF_CNT_W)) u_perf_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_wait),
    .cnt   (perf_wait_cnt)
  );

  hazard_sat_cnt #(.W(PERF_CNT_W)) u_perf_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_apply),
    .cnt   (perf_flush_cnt)
  );
`else
  assign perf_lu_cnt    = '0;
  assign perf_wait_cnt  = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

`default_nettype wire
